// File: rtl/pc_call_stack.sv
// Program counter with an integrated hardware return-address stack (call/return, sticky error flag).
// Optional build macro PCSTACK_TRAP_EN: stack/command errors send COUNT to TRAP_VECTOR instead of COUNT+1.
module pc_call_stack #(
    parameter int PC_WIDTH     = 5,
    parameter int STACK_DEPTH  = 4,
    parameter int RESET_VECTOR = 0,
    parameter int TRAP_VECTOR  = 31,
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                EN,
    input  logic                LOAD,
    input  logic                CALL,
    input  logic                RET,
    input  logic                CLR_ERR,
    input  logic [PC_WIDTH-1:0] DATA,
    output logic [PC_WIDTH-1:0] COUNT,
    output logic [SP_W-1:0]     SP,
    output logic                FULL,
    output logic                EMPTY,
    output logic                ERR
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

`ifdef PCSTACK_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [PC_WIDTH-1:0] count_r;
    logic [SP_W-1:0]     sp_r;
    logic                err_r;
    logic [PC_WIDTH-1:0] stack_r [STACK_DEPTH];

    logic [PC_WIDTH-1:0] count_plus1_s;
    logic [PC_WIDTH-1:0] err_count_s;
    logic [PC_WIDTH-1:0] count_next_s;
    logic [SP_W-1:0]     sp_next_s;
    logic                err_next_s;
    logic                push_s;
    logic                error_s;
    logic                full_s;
    logic                empty_s;
    logic [IDX_W-1:0]    push_idx_s;
    logic [IDX_W-1:0]    pop_idx_s;
    logic [2:0]          cmd_s;

    assign full_s  = (sp_r == SP_W'(STACK_DEPTH));
    assign empty_s = (sp_r == {SP_W{1'b0}});

    // Next-state decode for COUNT, SP, ERR and the push strobe
    always_comb begin
        count_plus1_s = count_r + PC_WIDTH'(1);
        err_count_s   = TRAP_EN ? PC_WIDTH'(TRAP_VECTOR) : count_plus1_s;
        push_idx_s    = IDX_W'(sp_r);
        pop_idx_s     = IDX_W'(sp_r - SP_W'(1));
        cmd_s         = {LOAD, CALL, RET};
        count_next_s  = count_r;
        sp_next_s     = sp_r;
        push_s        = 1'b0;
        error_s       = 1'b0;
        if (EN) begin
            case (cmd_s)
                3'b000: count_next_s = count_plus1_s;
                3'b100: count_next_s = DATA;
                3'b010: begin
                    if (full_s) begin
                        error_s      = 1'b1;
                        count_next_s = err_count_s;
                    end else begin
                        push_s       = 1'b1;
                        sp_next_s    = sp_r + SP_W'(1);
                        count_next_s = DATA;
                    end
                end
                3'b001: begin
                    if (empty_s) begin
                        error_s      = 1'b1;
                        count_next_s = err_count_s;
                    end else begin
                        sp_next_s    = sp_r - SP_W'(1);
                        count_next_s = stack_r[pop_idx_s];
                    end
                end
                default: begin
                    // Conflicting commands: no jump, push or pop
                    error_s      = 1'b1;
                    count_next_s = err_count_s;
                end
            endcase
        end else begin
            count_next_s = count_r;
            sp_next_s    = sp_r;
        end
        // A fresh error wins over a simultaneous clear request
        if (error_s) begin
            err_next_s = 1'b1;
        end else if (CLR_ERR) begin
            err_next_s = 1'b0;
        end else begin
            err_next_s = err_r;
        end
    end

    // Program counter, stack pointer and sticky error registers
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            count_r <= PC_WIDTH'(RESET_VECTOR);
            sp_r    <= {SP_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            sp_r    <= sp_next_s;
            err_r   <= err_next_s;
        end
    end

    // Return-address storage; popped entries keep their old contents
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {PC_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            stack_r[push_idx_s] <= count_plus1_s;
        end
    end

    assign COUNT = count_r;
    assign SP    = sp_r;
    assign ERR   = err_r;
    assign FULL  = full_s;
    assign EMPTY = empty_s;

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack at default parameters (PC_WIDTH=5, STACK_DEPTH=4).
module tb_pc_call_stack;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       EN = 1'b0, LOAD = 1'b0, CALL = 1'b0, RET = 1'b0, CLR_ERR = 1'b0;
    logic [4:0] DATA = 5'd0;
    logic [4:0] COUNT;
    logic [2:0] SP;
    logic       FULL, EMPTY, ERR;

    int checks = 0;
    int errors = 0;

    // control bits: {EN, LOAD, CALL, RET, CLR_ERR}
    localparam logic [4:0] IDLE = 5'b10000;
    localparam logic [4:0] LD   = 5'b11000;
    localparam logic [4:0] CA   = 5'b10100;
    localparam logic [4:0] RT   = 5'b10010;
    localparam logic [4:0] CL   = 5'b00001;
    localparam logic [4:0] OFF  = 5'b00000;

    typedef struct packed {
        logic [4:0] ctl;
        logic [4:0] data;
    } cmd_t;

    typedef struct packed {
        logic [4:0] count;
        logic [2:0] sp;
        logic       err;
        logic       full;
        logic       empty;
    } obs_t;

    obs_t sb[$];

    pc_call_stack dut (
        .CLOCK(CLOCK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .CALL(CALL), .RET(RET),
        .CLR_ERR(CLR_ERR), .DATA(DATA), .COUNT(COUNT), .SP(SP), .FULL(FULL),
        .EMPTY(EMPTY), .ERR(ERR)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic cmd_t mk(logic [4:0] ctl, logic [4:0] data);
        mk.ctl  = ctl;
        mk.data = data;
    endfunction

    function automatic obs_t ob(logic [4:0] count, logic [2:0] sp, logic err);
        ob.count = count;
        ob.sp    = sp;
        ob.err   = err;
        ob.full  = (sp == 3'd4);
        ob.empty = (sp == 3'd0);
    endfunction

    // COUNT after a stack/command error
    function automatic logic [4:0] eadv(logic [4:0] c);
`ifdef PCSTACK_TRAP_EN
        eadv = 5'd31;
`else
        eadv = c + 5'd1;
`endif
    endfunction

    function automatic string fmt(obs_t o);
        fmt = $sformatf("count=%0d sp=%0d err=%b full=%b empty=%b", o.count, o.sp, o.err, o.full, o.empty);
    endfunction

    function automatic obs_t sample();
        sample = {COUNT, SP, ERR, FULL, EMPTY};
    endfunction

    task automatic apply(cmd_t c);
        {EN, LOAD, CALL, RET, CLR_ERR} = c.ctl;
        DATA = c.data;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        {EN, LOAD, CALL, RET, CLR_ERR} = IDLE;
        RESET = 1'b0;
        sb.push_back(ob(5'd0, 3'd0, 1'b0));
        #12;
        got = sample();
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset: got %s, expected %s", fmt(got), fmt(exp));
        end
        {EN, LOAD, CALL, RET, CLR_ERR} = OFF;
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic test_wrap();
        cmd_t st[$];
        obs_t got, exp;
        for (int i = 1; i <= 33; i++) begin
            st.push_back(mk(IDLE, 5'd0));
            sb.push_back(ob(5'(i), 3'd0, 1'b0));
        end
        foreach (st[i]) begin
            apply(st[i]);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wrap[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_call_ret();
        cmd_t st[$];
        obs_t got, exp;
        st.push_back(mk(LD, 5'd3));    sb.push_back(ob(5'd3, 3'd0, 1'b0));
        st.push_back(mk(CA, 5'd10));   sb.push_back(ob(5'd10, 3'd1, 1'b0));
        st.push_back(mk(IDLE, 5'd0));  sb.push_back(ob(5'd11, 3'd1, 1'b0));
        st.push_back(mk(IDLE, 5'd0));  sb.push_back(ob(5'd12, 3'd1, 1'b0));
        st.push_back(mk(RT, 5'd0));    sb.push_back(ob(5'd4, 3'd0, 1'b0));
        foreach (st[i]) begin
            apply(st[i]);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL call_ret[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_nested();
        cmd_t st[$];
        obs_t got, exp;
        st.push_back(mk(LD, 5'd0));        sb.push_back(ob(5'd0, 3'd0, 1'b0));
        st.push_back(mk(CA, 5'd8));        sb.push_back(ob(5'd8, 3'd1, 1'b0));
        st.push_back(mk(CA, 5'd16));       sb.push_back(ob(5'd16, 3'd2, 1'b0));
        st.push_back(mk(CA, 5'd20));       sb.push_back(ob(5'd20, 3'd3, 1'b0));
        st.push_back(mk(CA, 5'd24));       sb.push_back(ob(5'd24, 3'd4, 1'b0));
        st.push_back(mk(CA, 5'd2));        sb.push_back(ob(eadv(5'd24), 3'd4, 1'b1));
        st.push_back(mk(RT, 5'd0));        sb.push_back(ob(5'd21, 3'd3, 1'b1));
        st.push_back(mk(RT, 5'd0));        sb.push_back(ob(5'd17, 3'd2, 1'b1));
        st.push_back(mk(RT, 5'd0));        sb.push_back(ob(5'd9, 3'd1, 1'b1));
        st.push_back(mk(RT, 5'd0));        sb.push_back(ob(5'd1, 3'd0, 1'b1));
        st.push_back(mk(IDLE | CL, 5'd0)); sb.push_back(ob(5'd2, 3'd0, 1'b0));
        foreach (st[i]) begin
            apply(st[i]);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL nested[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_underflow();
        cmd_t st[$];
        obs_t got, exp;
        st.push_back(mk(LD, 5'd6));   sb.push_back(ob(5'd6, 3'd0, 1'b0));
        st.push_back(mk(RT, 5'd0));   sb.push_back(ob(eadv(5'd6), 3'd0, 1'b1));
        st.push_back(mk(OFF, 5'd0));  sb.push_back(ob(eadv(5'd6), 3'd0, 1'b1));
        st.push_back(mk(CL, 5'd0));   sb.push_back(ob(eadv(5'd6), 3'd0, 1'b0));
        foreach (st[i]) begin
            apply(st[i]);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL underflow[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_illegal();
        cmd_t st[$];
        obs_t got, exp;
        st.push_back(mk(LD | CL, 5'd5));      sb.push_back(ob(5'd5, 3'd0, 1'b0));
        st.push_back(mk(LD | CA, 5'd12));     sb.push_back(ob(eadv(5'd5), 3'd0, 1'b1));
        st.push_back(mk(LD, 5'd20));          sb.push_back(ob(5'd20, 3'd0, 1'b1));
        st.push_back(mk(RT | CL, 5'd0));      sb.push_back(ob(eadv(5'd20), 3'd0, 1'b1));
        st.push_back(mk(LD | CL, 5'd20));     sb.push_back(ob(5'd20, 3'd0, 1'b0));
        st.push_back(mk(CA | RT, 5'd9));      sb.push_back(ob(eadv(5'd20), 3'd0, 1'b1));
        st.push_back(mk(LD, 5'd20));          sb.push_back(ob(5'd20, 3'd0, 1'b1));
        foreach (st[i]) begin
            apply(st[i]);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL illegal[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_hold();
        cmd_t st[$];
        obs_t got, exp;
        st.push_back(mk(5'b00100, 5'd9));  sb.push_back(ob(5'd20, 3'd0, 1'b1));
        st.push_back(mk(5'b01000, 5'd9));  sb.push_back(ob(5'd20, 3'd0, 1'b1));
        st.push_back(mk(CA, 5'd9));        sb.push_back(ob(5'd9, 3'd1, 1'b1));
        st.push_back(mk(5'b00010, 5'd0));  sb.push_back(ob(5'd9, 3'd1, 1'b1));
        st.push_back(mk(CL, 5'd0));        sb.push_back(ob(5'd9, 3'd1, 1'b0));
        st.push_back(mk(RT, 5'd0));        sb.push_back(ob(5'd21, 3'd0, 1'b0));
        foreach (st[i]) begin
            apply(st[i]);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_back_to_back();
        cmd_t st[$];
        obs_t got, exp;
        st.push_back(mk(CA, 5'd3));  sb.push_back(ob(5'd3, 3'd1, 1'b0));
        st.push_back(mk(RT, 5'd0));  sb.push_back(ob(5'd22, 3'd0, 1'b0));
        st.push_back(mk(CA, 5'd7));  sb.push_back(ob(5'd7, 3'd1, 1'b0));
        st.push_back(mk(CA, 5'd30)); sb.push_back(ob(5'd30, 3'd2, 1'b0));
        st.push_back(mk(RT, 5'd0));  sb.push_back(ob(5'd8, 3'd1, 1'b0));
        st.push_back(mk(RT, 5'd0));  sb.push_back(ob(5'd23, 3'd0, 1'b0));
        foreach (st[i]) begin
            apply(st[i]);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_async_reset();
        cmd_t st[$];
        obs_t got, exp;
        st.push_back(mk(LD, 5'd0));    sb.push_back(ob(5'd0, 3'd0, 1'b0));
        st.push_back(mk(RT, 5'd0));    sb.push_back(ob(eadv(5'd0), 3'd0, 1'b1));
        st.push_back(mk(LD, 5'd0));    sb.push_back(ob(5'd0, 3'd0, 1'b1));
        st.push_back(mk(CA, 5'd5));    sb.push_back(ob(5'd5, 3'd1, 1'b1));
        st.push_back(mk(CA, 5'd6));    sb.push_back(ob(5'd6, 3'd2, 1'b1));
        st.push_back(mk(CA, 5'd16));   sb.push_back(ob(5'd16, 3'd3, 1'b1));
        st.push_back(mk(IDLE, 5'd0));  sb.push_back(ob(5'd17, 3'd3, 1'b1));
        foreach (st[i]) begin
            apply(st[i]);
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_setup[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
        // assert reset mid-cycle, well away from any clock edge
        #2;
        sb.push_back(ob(5'd0, 3'd0, 1'b0));
        RESET = 1'b0;
        #1;
        got = sample();
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_reset: got %s, expected %s", fmt(got), fmt(exp));
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        sb.push_back(ob(5'd1, 3'd0, 1'b0));
        apply(mk(IDLE, 5'd0));
        got = sample();
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL post_reset: got %s, expected %s", fmt(got), fmt(exp));
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_call_ret();
        test_nested();
        test_underflow();
        test_illegal();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
